// File: rtl/svfloat_ftoi_arb.sv
// Round-robin arbitrated float-to-fixed-point converter: nreq requesters share
// one conversion datapath feeding a single registered output slot.

package svfloat;
  typedef struct packed {
    logic        sign;
    logic [4:0]  exponent;
    logic [9:0]  mantissa;
  } float16;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;

  typedef struct packed {
    logic        sign;
    logic [10:0] exponent;
    logic [51:0] mantissa;
  } float64;
endpackage

module svfloat_ftoi_arb #(
  parameter type float = svfloat::float32,
  parameter int  width = 32,
  parameter int  frac  = 0,
  parameter int  nreq  = 4,
  localparam int idw   = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [nreq-1:0]                      req_valid,
  output logic [nreq-1:0]                      req_ready,
  input  logic [nreq-1:0][$bits(float)-1:0]    req_data,
  input  logic [nreq-1:0]                      req_signed,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [width-1:0]                     out_data,
  output logic [idw-1:0]                       out_id,
  output logic                                 out_sat
);

  localparam int          fw   = $bits(float);
  localparam int          ew   = (fw == 64) ? 11 : (fw == 16) ? 5 : 8;
  localparam int          mw   = fw - 1 - ew;
  localparam int          bias = (1 << (ew - 1)) - 1;
  localparam int          xw   = mw + width + frac + 2;
  localparam int unsigned nr   = nreq;

  logic [idw-1:0] ptr_q;
  logic [idw-1:0] gnt_idx;
  logic           found;
  logic           can_accept;
  logic           xfer;
  int unsigned    idx;

  // Rotating priority search starting at ptr_q
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < nr; k++) begin
      idx = (32'(ptr_q) + k) % nr;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idw'(idx);
      end
    end
  end

  assign can_accept = !out_valid || out_ready;
  assign req_ready  = (found && can_accept && !rst) ? (nreq'(1) << gnt_idx) : '0;
  assign xfer       = |(req_valid & req_ready);

  logic [fw-1:0]    op;
  logic             op_sign;
  logic [ew-1:0]    op_exp;
  logic [mw-1:0]    op_man;
  logic             want_signed;
  int               unb;
  int               sh;
  logic [xw-1:0]    mant_x;
  logic [xw-1:0]    mag;
  logic [width-1:0] conv;
  logic             conv_sat;

  // Shift the implicit-one mantissa into fixed-point position; bits shifted
  // below the LSB are dropped, which truncates toward zero on the magnitude.
  always_comb begin
    op          = req_data[gnt_idx];
    op_sign     = op[fw-1];
    op_exp      = op[fw-2:mw];
    op_man      = op[mw-1:0];
    want_signed = req_signed[gnt_idx];
    unb         = int'(op_exp) - bias;
    sh          = 0;
    mant_x      = {{(xw-mw-1){1'b0}}, 1'b1, op_man};
    mag         = '0;
    conv        = '0;
    conv_sat    = 1'b0;
    if (&op_exp || unb >= width - 1) begin
      conv_sat         = 1'b1;
      conv[width-1]    = want_signed;
    end else if (op_exp != '0) begin
      sh = unb + frac - mw;
      if (sh >= 0)
        mag = mant_x << sh;
      else if (-sh < xw)
        mag = mant_x >> (-sh);
      conv = mag[width-1:0];
      if (op_sign)
        conv = -conv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
      ptr_q     <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= conv;
      out_id    <= gnt_idx;
      out_sat   <= conv_sat;
      ptr_q     <= (32'(gnt_idx) == nr - 1) ? '0 : gnt_idx + idw'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svfloat_ftoi_arb.sv
// Randomized self-checking bench for svfloat_ftoi_arb (float32, width 32,
// frac 0, four requesters) against a real-arithmetic reference model.

module tb_svfloat_ftoi_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_signed;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [1:0]       out_id;
  logic             out_sat;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  svfloat_ftoi_arb #(
    .float(svfloat::float32),
    .width(32),
    .frac (0),
    .nreq (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_signed(req_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_sat   (out_sat)
  );

  // Value = (2^23 + mantissa) * 2^(exp-150); $rtoi truncates toward zero.
  function automatic logic [31:0] ref_conv(input logic [31:0] f, input logic sgn,
                                           output logic sat);
    int          e;
    real         v;
    logic [31:0] m;
    e   = int'(f[30:23]);
    sat = 1'b0;
    if (e == 255 || e - 127 >= 31) begin
      sat = 1'b1;
      return {sgn, 31'b0};
    end
    if (e == 0) return 32'h0;
    v = (8388608.0 + real'(f[22:0])) * (2.0 ** (e - 150));
    m = 32'($rtoi(v));
    return f[31] ? -m : m;
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] rand_float();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return {1'($urandom), 8'(120 + $urandom_range(0, 40)), 23'($urandom)};
  endfunction

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_signed = '0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = 32'h3F800000;
    next_edge();
    next_edge();
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    checks++;
    if ({out_valid, out_data, out_id, out_sat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%0d sat=%b want all 0",
               out_valid, out_data, out_id, out_sat);
    end
    rst = 1'b0; req_valid = '0;
    m_ptr = 0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_data[0] = 32'h3FC00000; req_signed = '0; out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    next_edge();
    req_valid = '0;
    m_ptr = 1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1 || out_id !== 2'd0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got v=%b d=%h id=%0d sat=%b want v=1 d=00000001 id=0 sat=0",
               out_valid, out_data, out_id, out_sat);
    end
    next_edge();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_convert_table();
    logic [31:0] tdat [6] = '{32'hC0000000, 32'h7FC00000, 32'h53800000,
                              32'h4EFFFFFF, 32'h4F000000, 32'h3F7FFFFF};
    logic [1:0]  tidx [6] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    logic        tsgn [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_d;
    logic        exp_s;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      req_valid = '0; req_valid[tidx[t]] = 1'b1;
      req_data[tidx[t]] = tdat[t]; req_signed[tidx[t]] = tsgn[t];
      exp_d = ref_conv(tdat[t], tsgn[t], exp_s);
      next_edge();
      req_valid = '0;
      m_ptr = (int'(tidx[t]) + 1) % 4;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_id !== tidx[t] || out_sat !== exp_s) begin
        errors++;
        $display("FAIL convert_%h: got v=%b d=%h id=%0d sat=%b want v=1 d=%h id=%0d sat=%b",
                 tdat[t], out_valid, out_data, out_id, out_sat, exp_d, tidx[t], exp_s);
      end
    end
    next_edge();
  endtask

  task automatic test_fairness();
    int          g;
    logic [31:0] exp_d;
    logic        exp_s;
    rst = 1'b1; next_edge(); rst = 1'b0; m_ptr = 0;
    out_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_data[i] = rand_float(); req_signed[i] = 1'($urandom);
      end
      g = rr_pick(req_valid, m_ptr);
      exp_d = ref_conv(req_data[g], req_signed[g], exp_s);
      #1;
      next_edge();
      m_ptr = (g + 1) % 4;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(c % 4) || out_data !== exp_d || out_sat !== exp_s) begin
        errors++;
        $display("FAIL fairness_%0d: got v=%b id=%0d d=%h sat=%b want v=1 id=%0d d=%h sat=%b",
                 c, out_valid, out_id, out_data, out_sat, c % 4, exp_d, exp_s);
      end
    end
    req_valid = '0;
    next_edge();
  endtask

  task automatic test_backpressure();
    logic [31:0] hd;
    logic [1:0]  hid;
    logic        hs;
    int          g;
    out_ready = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i] = rand_float();
    next_edge();
    m_ptr = (m_ptr + 1) % 4;
    hd = out_data; hid = out_id; hs = out_sat;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) req_data[i] = rand_float();
      #1;
      checks++;
      if (req_ready !== 4'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_ready_%0d: got ready=%b v=%b want 0000 v=1", c, req_ready, out_valid);
      end
      next_edge();
      checks++;
      if (out_data !== hd || out_id !== hid || out_sat !== hs) begin
        errors++;
        $display("FAIL bp_hold_%0d: got d=%h id=%0d sat=%b want d=%h id=%0d sat=%b",
                 c, out_data, out_id, out_sat, hd, hid, hs);
      end
    end
    out_ready = 1'b1;
    g = rr_pick(req_valid, m_ptr);
    #1;
    checks++;
    if (req_ready !== 4'(1 << g)) begin
      errors++; $display("FAIL bp_release: got ready=%b want %b", req_ready, 4'(1 << g));
    end
    next_edge();
    m_ptr = (g + 1) % 4;
    req_valid = '0;
    next_edge();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; next_edge(); rst = 1'b0;
    out_ready = 1'b0; req_valid = 4'b0010; req_data[1] = 32'h40400000;
    next_edge();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1) begin
      errors++; $display("FAIL midrst_setup: got v=%b id=%0d want v=1 id=1", out_valid, out_id);
    end
    rst = 1'b1; req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL midrst_ready: got %b want 0000", req_ready);
    end
    next_edge();
    checks++;
    if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 32'h0) begin
      errors++; $display("FAIL midrst_clear: got v=%b id=%0d d=%h want 0", out_valid, out_id, out_data);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    next_edge();
    m_ptr = 1;
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      errors++; $display("FAIL midrst_first_grant: got v=%b id=%0d want v=1 id=0", out_valid, out_id);
    end
    req_valid = '0;
    next_edge();
  endtask

  task automatic test_random();
    logic [3:0]  pend = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_id = '0;
    logic        m_sat = 1'b0;
    logic [3:0]  exp_rdy;
    int          g;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_id !== m_id ||
          out_sat !== m_sat))) begin
        errors++;
        $display("FAIL random_out_%0d: got v=%b d=%h id=%0d sat=%b want v=%b d=%h id=%0d sat=%b",
                 c, out_valid, out_data, out_id, out_sat, m_valid, m_data, m_id, m_sat);
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; req_data[i] = rand_float(); req_signed[i] = 1'($urandom);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req_valid = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      g = (!m_valid || out_ready) ? rr_pick(pend, m_ptr) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL random_ready_%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      if (g >= 0) begin
        m_valid = 1'b1; m_id = 2'(g);
        m_data = ref_conv(req_data[g], req_signed[g], m_sat);
        m_ptr = (g + 1) % 4; pend[g] = 1'b0;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      next_edge();
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_signed = '0; out_ready = 1'b0; req_data = '0;
    next_edge();
    test_reset();
    test_single();
    test_convert_table();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
